// File: rtl/colour_fx_pipe.sv
// colour_fx_pipe: frame-synchronous colour effects on a vid_io pixel stream with debounced button control.
// Define COLOUR_FX_FRAME_CNT_EN to add the o_frame_cnt vsync-rise counter port.
module colour_fx_pipe #(
  parameter int CH_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [3*CH_WIDTH-1:0] i_vid_data,
  input  logic                  i_vid_hsync,
  input  logic                  i_vid_vsync,
  input  logic                  i_vid_VDE,
  output logic [3*CH_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  input  logic [3:0]            btn,
  input  logic [3:0]            sw,
  output logic [2:0]            o_mode
`ifdef COLOUR_FX_FRAME_CNT_EN
  ,
  output logic [15:0]           o_frame_cnt
`endif
);
  localparam int DW = 3 * CH_WIDTH;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CH_WIDTH-1:0] STEP    = CH_WIDTH'(1) << (CH_WIDTH - 4);
  localparam logic [CH_WIDTH-1:0] THR_RST = CH_WIDTH'(1) << (CH_WIDTH - 1);
  typedef enum logic [2:0] {BYPASS = 3'd0, SWAP = 3'd1, INVERT = 3'd2, GREY = 3'd3, BINARY = 3'd4} mode_t;
  logic [3:0] sync1_q, sync2_q, deb_q, deb_prev_q, press;
  logic [CW-1:0] cnt_q [4];
  mode_t mode_p_q, mode_p_d, mode_q;
  logic [2:0] perm_p_q, perm_q;
  logic [CH_WIDTH-1:0] thr_p_q, thr_p_d, thr_q;
  logic [DW-1:0] s1_data_q, perm_pix, fx;
  logic s1_hs_q, s1_vs_q, s1_de_q, commit, sw_unused;
  logic [CH_WIDTH-1:0] s1_g_q, c2, c1, c0, g_in, i2, i1, i0;
  logic [CH_WIDTH+1:0] g_sum;
  assign sw_unused = sw[3];
  assign press = deb_q & ~deb_prev_q;
  assign commit = i_vid_vsync & ~s1_vs_q;
  assign o_mode = mode_q;
  // Synchronise each button and flip its debounced level after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[i] <= '0;
          deb_q[i] <= ~deb_q[i];
        end else cnt_q[i] <= cnt_q[i] + CW'(1);
      end
    end
  end
  // Next pending mode/threshold from this cycle's press events; btn1 reset beats btn0 step, btn2+btn3 cancel.
  always_comb begin
    mode_p_d = press[1] ? BYPASS : press[0] ? (mode_p_q == BINARY ? BYPASS : mode_t'(mode_p_q + 3'd1)) : mode_p_q;
    thr_p_d = (press[2] ^ press[3]) ? (press[2] ? thr_p_q + STEP : thr_p_q - STEP) : thr_p_q;
  end
  // Stage pending configuration every cycle and commit it to the active set only on a vsync rise.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mode_p_q <= BYPASS;
      mode_q <= BYPASS;
      perm_p_q <= '0;
      perm_q <= '0;
      thr_p_q <= THR_RST;
      thr_q <= THR_RST;
    end else begin
      mode_p_q <= mode_p_d;
      thr_p_q <= thr_p_d;
      perm_p_q <= sw[2:0];
      if (commit) begin
        mode_q <= mode_p_d;
        thr_q <= thr_p_d;
        perm_q <= perm_p_q;
      end
    end
  end
  assign {i2, i1, i0} = i_vid_data;
  assign g_sum = {2'b00, i2} + {1'b0, i1, 1'b0} + {2'b00, i0};
  assign g_in = g_sum[CH_WIDTH+1:2];
  assign {c2, c1, c0} = s1_data_q;
  // Channel permutation of the stage-1 pixel; unused codes fall back to identity.
  always_comb begin
    case (perm_q)
      3'd1: perm_pix = {c1, c2, c0};
      3'd2: perm_pix = {c0, c1, c2};
      3'd3: perm_pix = {c2, c0, c1};
      3'd4: perm_pix = {c1, c0, c2};
      3'd5: perm_pix = {c0, c2, c1};
      default: perm_pix = s1_data_q;
    endcase
  end
  // Effect select driven by the active mode; blanked pixels are forced to zero.
  always_comb begin
    fx = mode_q == SWAP ? perm_pix :
         mode_q == INVERT ? ~s1_data_q :
         mode_q == GREY ? {3{s1_g_q}} :
         mode_q == BINARY ? {DW{s1_g_q >= thr_q}} : s1_data_q;
  end
  // Two-stage pipeline: stage 1 captures pixel, syncs and grey; stage 2 registers the effect output.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_data_q <= '0;
      s1_hs_q <= 1'b0;
      s1_vs_q <= 1'b0;
      s1_de_q <= 1'b0;
      s1_g_q <= '0;
      o_vid_data <= '0;
      o_vid_hsync <= 1'b0;
      o_vid_vsync <= 1'b0;
      o_vid_VDE <= 1'b0;
    end else begin
      s1_data_q <= i_vid_data;
      s1_hs_q <= i_vid_hsync;
      s1_vs_q <= i_vid_vsync;
      s1_de_q <= i_vid_VDE;
      s1_g_q <= g_in;
      o_vid_data <= s1_de_q ? fx : '0;
      o_vid_hsync <= s1_hs_q;
      o_vid_vsync <= s1_vs_q;
      o_vid_VDE <= s1_de_q;
    end
  end
`ifdef COLOUR_FX_FRAME_CNT_EN
  logic [15:0] frame_q;
  assign o_frame_cnt = frame_q;
  // Count vsync rising edges, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!n_rst) frame_q <= '0;
    else if (commit) frame_q <= frame_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_colour_fx_pipe.sv
// tb_colour_fx_pipe: directed scoreboard bench for colour_fx_pipe (CH_WIDTH=8, DEBOUNCE_CYCLES=4).
module tb_colour_fx_pipe;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic [23:0] i_vid_data = '0;
  logic i_vid_hsync = 1'b0, i_vid_vsync = 1'b0, i_vid_VDE = 1'b0;
  logic [23:0] o_vid_data;
  logic o_vid_hsync, o_vid_vsync, o_vid_VDE;
  logic [3:0] btn = '0, sw = '0;
  logic [2:0] o_mode;
`ifdef COLOUR_FX_FRAME_CNT_EN
  logic [15:0] o_frame_cnt;
`endif
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {int due; logic [23:0] data; logic hs; logic vs; logic de;} exp_t;
  exp_t q[$];

  colour_fx_pipe #(.CH_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_vid_data(i_vid_data), .i_vid_hsync(i_vid_hsync), .i_vid_vsync(i_vid_vsync), .i_vid_VDE(i_vid_VDE),
    .o_vid_data(o_vid_data), .o_vid_hsync(o_vid_hsync), .o_vid_vsync(o_vid_vsync), .o_vid_VDE(o_vid_VDE),
    .btn(btn), .sw(sw), .o_mode(o_mode)
`ifdef COLOUR_FX_FRAME_CNT_EN
    , .o_frame_cnt(o_frame_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop every expectation whose output cycle has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.due < cyc) chk("stale_entry", 32'(cyc), 32'(e.due));
      else begin
        chk("o_vid_data", {8'h0, o_vid_data}, {8'h0, e.data});
        chk("o_vid_VDE", {31'h0, o_vid_VDE}, {31'h0, e.de});
        chk("o_vid_hsync", {31'h0, o_vid_hsync}, {31'h0, e.hs});
        chk("o_vid_vsync", {31'h0, o_vid_vsync}, {31'h0, e.vs});
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic [23:0] d, logic de, logic hs, logic vs, logic [23:0] exp);
    exp_t e;
    i_vid_data = d;
    i_vid_VDE = de;
    i_vid_hsync = hs;
    i_vid_vsync = vs;
    e.due = cyc + 2;
    e.data = exp;
    e.de = de;
    e.hs = hs;
    e.vs = vs;
    q.push_back(e);
    tick(1);
  endtask

  task automatic idle(int n);
    i_vid_data = '0;
    i_vid_VDE = 1'b0;
    i_vid_hsync = 1'b0;
    i_vid_vsync = 1'b0;
    tick(n);
  endtask

  task automatic vs_pulse();
    drive(24'h0, 1'b0, 1'b0, 1'b1, 24'h0);
    drive(24'h0, 1'b0, 1'b0, 1'b1, 24'h0);
    drive(24'h0, 1'b0, 1'b0, 1'b0, 24'h0);
    drive(24'h0, 1'b0, 1'b0, 1'b0, 24'h0);
    idle(2);
  endtask

  task automatic press(logic [3:0] b);
    btn = b;
    tick(8);
    btn = '0;
    tick(8);
  endtask

  task automatic go_mode(int steps);
    press(4'b0010);
    repeat (steps) press(4'b0001);
    vs_pulse();
    chk("o_mode_commit", {29'h0, o_mode}, 32'(steps));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    chk("rst_data", {8'h0, o_vid_data}, 32'h0);
    chk("rst_VDE", {31'h0, o_vid_VDE}, 32'h0);
    chk("rst_mode", {29'h0, o_mode}, 32'h0);
`ifdef COLOUR_FX_FRAME_CNT_EN
    chk("rst_frame_cnt", {16'h0, o_frame_cnt}, 32'h0);
`endif
    n_rst = 1'b1;
    tick(2);
    drive(24'h112233, 1'b1, 1'b1, 1'b0, 24'h112233);
    drive(24'h445566, 1'b1, 1'b0, 1'b0, 24'h445566);
    idle(3);
    chk("bypass_mode", {29'h0, o_mode}, 32'h0);
    // Swap mode staged mid-frame, visible only after vsync.
    sw = 4'd1;
    press(4'b0001);
    chk("mode_before_vsync", {29'h0, o_mode}, 32'h0);
    vs_pulse();
    chk("mode_after_vsync", {29'h0, o_mode}, 32'h1);
    drive(24'h112233, 1'b1, 1'b1, 1'b0, 24'h221133);
    idle(3);
    sw = 4'd0;
    press(4'b0010);
    vs_pulse();
    chk("btn1_to_bypass", {29'h0, o_mode}, 32'h0);
    // Bouncing button must never register a press.
    for (int i = 0; i < 20; i++) begin
      btn[0] = ~btn[0];
      tick(2);
    end
    btn = '0;
    tick(10);
    vs_pulse();
    chk("bounce_mode", {29'h0, o_mode}, 32'h0);
    go_mode(3);
    drive(24'h4080C0, 1'b1, 1'b1, 1'b0, 24'h808080);
    drive(24'h4080C0, 1'b0, 1'b0, 1'b0, 24'h000000);
    idle(3);
    go_mode(2);
    drive(24'h112233, 1'b1, 1'b1, 1'b0, 24'hEEDDCC);
    drive(24'h112233, 1'b0, 1'b0, 1'b0, 24'h000000);
    idle(3);
    // Binary threshold: 0x80 reset, +0x10, both buttons cancel, -0x10.
    go_mode(4);
    drive(24'h4080C0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
    idle(3);
    press(4'b0100);
    vs_pulse();
    drive(24'h4080C0, 1'b1, 1'b1, 1'b0, 24'h000000);
    drive(24'h909090, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
    idle(3);
    press(4'b1100);
    vs_pulse();
    drive(24'h4080C0, 1'b1, 1'b1, 1'b0, 24'h000000);
    drive(24'h909090, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
    idle(3);
    press(4'b1000);
    vs_pulse();
    drive(24'h4080C0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
    idle(3);
    // Mid-frame reset in grey mode.
    go_mode(3);
    drive(24'h4080C0, 1'b1, 1'b1, 1'b0, 24'h808080);
    tick(2);
    n_rst = 1'b0;
    tick(1);
    chk("midrst_data", {8'h0, o_vid_data}, 32'h0);
    chk("midrst_VDE", {31'h0, o_vid_VDE}, 32'h0);
    chk("midrst_hsync", {31'h0, o_vid_hsync}, 32'h0);
    chk("midrst_mode", {29'h0, o_mode}, 32'h0);
`ifdef COLOUR_FX_FRAME_CNT_EN
    chk("midrst_frame_cnt", {16'h0, o_frame_cnt}, 32'h0);
`endif
    n_rst = 1'b1;
    drive(24'h4080C0, 1'b1, 1'b1, 1'b0, 24'h4080C0);
    idle(3);
`ifdef COLOUR_FX_FRAME_CNT_EN
    repeat (3) vs_pulse();
    chk("frame_cnt_3", {16'h0, o_frame_cnt}, 32'h3);
`endif
    idle(4);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
